// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, shadow-entry type and select-code helper for the hazard controller
package hazard_pkg;
  localparam int FWD_RF = 0;
  localparam int RD_W = 8;
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            is_load;
  } shd_entry_t;
  // Stage index s counts E=0, M1=1 .. Mk=k, W=k+1; M1 gets the largest code, W gets 1
  function automatic int fwd_code(input int s, input int k);
    return k + 2 - s;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D/E-stage tags in, stall/flush/forward controls and counters out
interface hazard_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2
);
  logic                  valid_d;
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  reg_write_d;
  logic                  is_load_d;
  logic                  pc_src_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic [FWD_W-1:0]      fwd_a_e;
  logic [FWD_W-1:0]      fwd_b_e;
  logic [DATA_WIDTH-1:0] stall_count;
  logic [DATA_WIDTH-1:0] flush_count;
  modport master (
    output valid_d, rs1_d, rs2_d, rd_d, reg_write_d, is_load_d, pc_src_e,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_count, flush_count
  );
  modport slave (
    input  valid_d, rs1_d, rs2_d, rd_d, reg_write_d, is_load_d, pc_src_e,
    output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_shadow_pipe.sv
// hazard_shadow_pipe: destination-tag shift chain E -> M1..Mk -> W with bubble insertion at E
module hazard_shadow_pipe
  import hazard_pkg::*;
#(
  parameter int MEM_STAGES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_e_i,
  input  shd_entry_t                   entry_i,
  output shd_entry_t [MEM_STAGES+1:0]  stage_o
);
  shd_entry_t [MEM_STAGES+1:0] stage_q;
  // Index 0 is E; every stage moves one step older each cycle
  always_ff @(posedge clk)
    if (rst) stage_q <= '0;
    else stage_q <= {stage_q[MEM_STAGES:0], flush_e_i ? shd_entry_t'('0) : entry_i};
  assign stage_o = stage_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding selects, load-use stalls, redirect flushes and event counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_STAGES = 1,
  parameter int FWD_W      = $clog2(MEM_STAGES + 2)
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int W = MEM_STAGES + 1;
  shd_entry_t [W:0]      stg;
  shd_entry_t            entry;
  logic [REG_ADDR_W-1:0] rs1_e_q, rs2_e_q;
  logic [FWD_W-1:0]      fwd_a, fwd_b;
  logic [DATA_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
  logic                  load_use, redirect, stall, flush_e;
  function automatic logic hit(input shd_entry_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.valid && e.reg_write && (rs != '0) && (e.rd == RD_W'(rs));
  endfunction
  assign entry = '{valid: bus.valid_d, rd: RD_W'(bus.rd_d),
                   reg_write: bus.reg_write_d && (bus.rd_d != '0), is_load: bus.is_load_d};
  hazard_shadow_pipe #(.MEM_STAGES(MEM_STAGES)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush_e_i (flush_e),
    .entry_i   (entry),
    .stage_o   (stg)
  );
  // Walk oldest to youngest so the youngest matching stage wins; loads forward only from W
  always_comb begin
    fwd_a = FWD_W'(FWD_RF);
    fwd_b = FWD_W'(FWD_RF);
    load_use = 1'b0;
    for (int s = W; s >= 1; s--) begin
      if (hit(stg[s], rs1_e_q) && (!stg[s].is_load || s == W)) fwd_a = FWD_W'(fwd_code(s, MEM_STAGES));
      if (hit(stg[s], rs2_e_q) && (!stg[s].is_load || s == W)) fwd_b = FWD_W'(fwd_code(s, MEM_STAGES));
    end
    for (int s = 0; s < MEM_STAGES; s++)
      if (stg[s].is_load && (hit(stg[s], bus.rs1_d) || hit(stg[s], bus.rs2_d))) load_use = 1'b1;
    load_use = load_use && bus.valid_d;
  end
  assign redirect        = bus.pc_src_e;
  assign stall           = load_use && !redirect;
  assign flush_e         = load_use || redirect;
  assign bus.stall_f     = stall;
  assign bus.stall_d     = stall;
  assign bus.flush_d     = redirect;
  assign bus.flush_e     = flush_e;
  assign bus.fwd_a_e     = fwd_a;
  assign bus.fwd_b_e     = fwd_b;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
  // E-stage source registers follow the entry into E and are zeroed for bubbles
  always_ff @(posedge clk)
    if (rst || flush_e || !bus.valid_d) {rs1_e_q, rs2_e_q} <= '0;
    else {rs1_e_q, rs2_e_q} <= {bus.rs1_d, bus.rs2_d};
  // Saturating stall and redirect counters
  always_ff @(posedge clk)
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + DATA_WIDTH'(1);
      if (redirect && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + DATA_WIDTH'(1);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, flushes, reset and counter saturation
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.DATA_WIDTH(32), .REG_ADDR_W(5), .FWD_W(2)) bus1 ();
  hazard_ctrl_if #(.DATA_WIDTH(2), .REG_ADDR_W(5), .FWD_W(3)) bus3 ();
  hazard_ctrl #(.DATA_WIDTH(32), .REG_ADDR_W(5), .MEM_STAGES(1), .FWD_W(2)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );
  hazard_ctrl #(.DATA_WIDTH(2), .REG_ADDR_W(5), .MEM_STAGES(3), .FWD_W(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic d1(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                    input logic w, input logic ld);
    bus1.valid_d = v;
    bus1.rs1_d = r1;
    bus1.rs2_d = r2;
    bus1.rd_d = rd;
    bus1.reg_write_d = w;
    bus1.is_load_d = ld;
    #1;
  endtask
  task automatic d3(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                    input logic w, input logic ld);
    bus3.valid_d = v;
    bus3.rs1_d = r1;
    bus3.rs2_d = r2;
    bus3.rd_d = rd;
    bus3.reg_write_d = w;
    bus3.is_load_d = ld;
    #1;
  endtask
  initial begin
    bus1.pc_src_e = 1'b0;
    bus3.pc_src_e = 1'b0;
    d1(0, 0, 0, 0, 0, 0);
    d3(0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    rst = 1'b0;
    #1;
    chk("rst_stall_f", 32'(bus1.stall_f), 0);
    chk("rst_stall_d", 32'(bus1.stall_d), 0);
    chk("rst_flush_d", 32'(bus1.flush_d), 0);
    chk("rst_flush_e", 32'(bus1.flush_e), 0);
    chk("rst_fwd_a", 32'(bus1.fwd_a_e), 0);
    chk("rst_fwd_b", 32'(bus1.fwd_b_e), 0);
    chk("rst_stall_cnt", bus1.stall_count, 0);
    chk("rst_flush_cnt", bus1.flush_count, 0);
    chk("rst_k3_stall_cnt", 32'(bus3.stall_count), 0);
    tick; d1(1, 0, 0, 5, 1, 0);
    tick; d1(1, 5, 1, 6, 1, 0);
    tick; d1(1, 5, 0, 10, 1, 0);
    chk("raw_m1_fwd_a", 32'(bus1.fwd_a_e), 2);
    chk("raw_m1_fwd_b", 32'(bus1.fwd_b_e), 0);
    chk("raw_no_stall", 32'(bus1.stall_d), 0);
    tick; d1(0, 0, 0, 0, 0, 0);
    chk("raw_w_fwd_a", 32'(bus1.fwd_a_e), 1);
    tick; d1(1, 0, 0, 7, 1, 1);
    tick; d1(1, 7, 7, 8, 1, 0);
    chk("lu_stall_f", 32'(bus1.stall_f), 1);
    chk("lu_stall_d", 32'(bus1.stall_d), 1);
    chk("lu_flush_e", 32'(bus1.flush_e), 1);
    chk("lu_flush_d", 32'(bus1.flush_d), 0);
    tick; d1(1, 7, 7, 8, 1, 0);
    chk("lu_released", 32'(bus1.stall_d), 0);
    chk("lu_released_fe", 32'(bus1.flush_e), 0);
    tick; d1(0, 0, 0, 0, 0, 0);
    chk("lu_fwd_a_w", 32'(bus1.fwd_a_e), 1);
    chk("lu_fwd_b_w", 32'(bus1.fwd_b_e), 1);
    chk("lu_stall_cnt", bus1.stall_count, 1);
    tick; d1(1, 0, 0, 0, 1, 0);
    tick; d1(1, 0, 0, 11, 1, 0);
    tick; d1(0, 0, 0, 0, 0, 0);
    chk("x0_fwd_a", 32'(bus1.fwd_a_e), 0);
    chk("x0_fwd_b", 32'(bus1.fwd_b_e), 0);
    tick; d1(1, 0, 0, 9, 1, 0);
    tick; d1(1, 0, 0, 9, 1, 0);
    tick; d1(1, 9, 9, 14, 1, 0);
    tick; d1(0, 0, 0, 0, 0, 0);
    chk("prio_fwd_a", 32'(bus1.fwd_a_e), 2);
    chk("prio_fwd_b", 32'(bus1.fwd_b_e), 2);
    tick; d1(1, 0, 0, 12, 1, 1);
    tick; bus1.pc_src_e = 1'b1; d1(1, 12, 0, 15, 1, 0);
    chk("redir_flush_d", 32'(bus1.flush_d), 1);
    chk("redir_flush_e", 32'(bus1.flush_e), 1);
    chk("redir_stall_d", 32'(bus1.stall_d), 0);
    chk("redir_stall_f", 32'(bus1.stall_f), 0);
    tick; bus1.pc_src_e = 1'b0; d1(0, 0, 0, 0, 0, 0);
    chk("redir_flush_cnt", bus1.flush_count, 1);
    chk("redir_stall_cnt", bus1.stall_count, 1);
    chk("redir_flush_e_off", 32'(bus1.flush_e), 0);
    tick; d1(1, 0, 0, 13, 1, 1);
    tick; d1(1, 13, 0, 16, 1, 0);
    chk("mid_rst_pre_stall", 32'(bus1.stall_d), 1);
    rst = 1'b1;
    tick; rst = 1'b0; d1(1, 13, 0, 16, 1, 0);
    chk("mid_rst_stall_d", 32'(bus1.stall_d), 0);
    chk("mid_rst_flush_e", 32'(bus1.flush_e), 0);
    chk("mid_rst_fwd_a", 32'(bus1.fwd_a_e), 0);
    chk("mid_rst_stall_cnt", bus1.stall_count, 0);
    chk("mid_rst_flush_cnt", bus1.flush_count, 0);
    tick; d1(0, 0, 0, 0, 0, 0);
    tick; d3(1, 0, 0, 7, 1, 1);
    tick; d3(1, 7, 7, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("k3_lu_stall", 32'(bus3.stall_d), 1);
      tick; d3(1, 7, 7, 8, 1, 0);
    end
    chk("k3_lu_release", 32'(bus3.stall_d), 0);
    tick; d3(0, 0, 0, 0, 0, 0);
    chk("k3_fwd_a_w", 32'(bus3.fwd_a_e), 1);
    chk("k3_fwd_b_w", 32'(bus3.fwd_b_e), 1);
    chk("k3_stall_cnt", 32'(bus3.stall_count), 3);
    tick; d3(1, 0, 0, 20, 1, 0);
    tick; d3(1, 20, 0, 21, 1, 0);
    tick; d3(1, 0, 20, 22, 1, 0);
    chk("k3_fwd_m1", 32'(bus3.fwd_a_e), 4);
    tick; d3(0, 0, 0, 0, 0, 0);
    chk("k3_fwd_m2", 32'(bus3.fwd_b_e), 3);
    chk("k3_fwd_a_none", 32'(bus3.fwd_a_e), 0);
    tick; d3(1, 0, 0, 7, 1, 1);
    tick; d3(1, 7, 0, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("sat_stall", 32'(bus3.stall_d), 1);
      tick; d3(1, 7, 0, 8, 1, 0);
    end
    chk("sat_stall_cnt", 32'(bus3.stall_count), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
